// File: rtl/serial_fas_engine_pkg.sv
// Shared types and constants for the bit-serial full adder/subtractor engine.
package serial_fas_engine_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic ADD = 1'b1;
   localparam logic SUB = 1'b0;

   // Bit-counter width; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_fas_engine_fas.sv
// One full adder/subtractor bit-slice: f = a XNOR a_ns, sum = f^b^cin, cout = maj(f,b,cin).
module fas_cell #(
   parameter int NAND_TPD = 1,
   parameter int OR_TPD   = 1,
   parameter int XNOR_TPD = 1
) (
   input  logic a,
   input  logic b,
   input  logic a_ns,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Gate delays describe the library cell; they only gate elaboration here.
   localparam int CELL_TPD = ((XNOR_TPD > OR_TPD) ? XNOR_TPD : OR_TPD) + 2 * NAND_TPD;

   if (CELL_TPD < 0) begin : g_bad_tpd
      $error("fas_cell: negative gate delay");
   end

   logic f;
   logic fb_or;
   logic n_fb;
   logic n_cfb;

   assign f     = ~(a ^ a_ns);
   assign fb_or = f | b;
   assign n_fb  = ~(f & b);
   assign n_cfb = ~(cin & fb_or);
   assign cout  = ~(n_fb & n_cfb);
   assign sum   = f ^ b ^ cin;

endmodule

// File: rtl/serial_fas_engine.sv
// Bit-serial WIDTH-bit adder/subtractor: one fas cell, one bit per clock, LSB first.
module serial_fas_engine
   import serial_fas_engine_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NAND_TPD = 1,
   parameter int OR_TPD   = 1,
   parameter int XNOR_TPD = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             a_ns,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state, state_nxt;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-2:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic [CW-1:0]    cnt;
   logic             mode;
   logic             carry;
   logic             cell_sum;
   logic             cell_cout;

   fas_cell #(
      .NAND_TPD (NAND_TPD),
      .OR_TPD   (OR_TPD),
      .XNOR_TPD (XNOR_TPD)
   ) u_cell (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .a_ns (mode),
      .cin  (carry),
      .sum  (cell_sum),
      .cout (cell_cout)
   );

   // Shadow register collects the low bits; the live sum bit completes the word.
   assign sum_nxt = {cell_sum, sum_sh};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         mode   <= ADD;
         carry  <= 1'b0;
         res    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_a  <= a;
               op_b  <= b;
               mode  <= a_ns;
               carry <= ~a_ns;
               cnt   <= '0;
            end
            RUN: begin
               op_a   <= op_a >> 1;
               op_b   <= op_b >> 1;
               sum_sh <= sum_nxt[WIDTH-1:1];
               carry  <= cell_cout;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB here
                  res  <= sum_nxt;
                  cout <= cell_cout;
                  ovf  <= carry ^ cell_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
